// File: rtl/cic_decimator_if.sv
// Sample-stream bundle for the CIC decimator: input samples with a valid
// qualifier in, decimated samples with a one-cycle strobe out.
interface cic_decimator_if #(
    parameter int INPUT_WIDTH  = 14,
    parameter int OUTPUT_WIDTH = 14
);
    logic signed [INPUT_WIDTH-1:0]  DATA_IN;
    logic                           DATA_IN_VALID;
    logic signed [OUTPUT_WIDTH-1:0] DATA_OUT;
    logic                           DATA_OUT_VALID;

    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        input  DATA_OUT,
        input  DATA_OUT_VALID
    );

    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        output DATA_OUT,
        output DATA_OUT_VALID
    );
endinterface

// File: rtl/cic_decimator.sv
// N-stage Hogenauer CIC decimator by 2^LOG2_DECIMATION with pipelined integrators,
// a strobe-tracked comb pipeline and a truncating output scaler.
module cic_decimator #(
    parameter int INPUT_WIDTH     = 14,
    parameter int OUTPUT_WIDTH    = 14,
    parameter int STAGES          = 3,
    parameter int LOG2_DECIMATION = 4
) (
    input  logic           clk,
    input  logic           rst,
    cic_decimator_if.slave bus
);
    localparam int W     = INPUT_WIDTH + STAGES * LOG2_DECIMATION;
    localparam int SHIFT = W - OUTPUT_WIDTH;

    logic signed [W-1:0] integ_q   [1:STAGES];
    logic signed [W-1:0] integ_d   [1:STAGES];
    logic signed [W-1:0] integ_src [1:STAGES];
    logic signed [W-1:0] comb_q    [0:STAGES];
    logic signed [W-1:0] comb_d    [0:STAGES];
    logic signed [W-1:0] delay_q   [1:STAGES];
    logic signed [W-1:0] delay_d   [1:STAGES];
    logic [STAGES:0]     vld_q, vld_d;

    logic [LOG2_DECIMATION-1:0]     cnt_q, cnt_d;
    logic                           tap_q, tap_d;
    logic signed [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic                           out_valid_q, out_valid_d;

    logic signed [W-1:0] data_ext;
    logic signed [W-1:0] comb_shifted;

    assign data_ext     = {{(W - INPUT_WIDTH){bus.DATA_IN[INPUT_WIDTH-1]}}, bus.DATA_IN};
    assign comb_shifted = comb_q[STAGES] >>> SHIFT;

    // Each integrator adds the pre-edge value of the stage before it, so the
    // chain is one register deep per stage rather than one long adder path.
    for (genvar gi = 1; gi <= STAGES; gi++) begin : g_integ_src
        if (gi == 1) begin : g_first
            assign integ_src[gi] = data_ext;
        end else begin : g_rest
            assign integ_src[gi] = integ_q[gi-1];
        end
    end

    always_comb begin
        integ_d = integ_q;
        cnt_d   = cnt_q;
        tap_d   = 1'b0;
        if (bus.DATA_IN_VALID) begin
            for (int k = 1; k <= STAGES; k++) begin
                integ_d[k] = integ_q[k] + integ_src[k];
            end
            cnt_d = cnt_q + 1'b1;
            tap_d = (cnt_q == {LOG2_DECIMATION{1'b1}});
        end
    end

    // Comb stages only move when the strobe reaches them; otherwise they hold.
    always_comb begin
        comb_d   = comb_q;
        delay_d  = delay_q;
        vld_d    = '0;
        vld_d[0] = tap_q;
        if (tap_q) begin
            comb_d[0] = integ_q[STAGES];
        end
        for (int k = 1; k <= STAGES; k++) begin
            if (vld_q[k-1]) begin
                comb_d[k]  = comb_q[k-1] - delay_q[k];
                delay_d[k] = comb_q[k-1];
                vld_d[k]   = 1'b1;
            end
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = vld_q[STAGES];
        if (vld_q[STAGES]) begin
            out_d = comb_shifted[OUTPUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                integ_q[k] <= '0;
                delay_q[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                comb_q[k] <= '0;
            end
            vld_q       <= '0;
            cnt_q       <= '0;
            tap_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            integ_q     <= integ_d;
            comb_q      <= comb_d;
            delay_q     <= delay_d;
            vld_q       <= vld_d;
            cnt_q       <= cnt_d;
            tap_q       <= tap_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.DATA_OUT       = out_q;
    assign bus.DATA_OUT_VALID = out_valid_q;
endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
- Multi-stage CIC (Hogenauer) decimating low-pass filter on the demodulated path.
- Consumes the narrow signed product from the mixer stage, removes the 2f image and out-of-band products, and decimates by 2^LOG2_DECIMATION.
- Output is a reduced-rate signed sample stream with a one-cycle valid strobe, feeding the downstream phase/loop logic.
- DC gain is unity when OUTPUT_WIDTH equals INPUT_WIDTH.

Parameters:
- INPUT_WIDTH, 14: width of the signed input sample.
- OUTPUT_WIDTH, 14: width of the signed output sample. Must satisfy 1 <= OUTPUT_WIDTH <= INPUT_WIDTH + STAGES*LOG2_DECIMATION.
- STAGES, 3: number of integrator stages and number of comb stages (N). Legal range 1..6.
- LOG2_DECIMATION, 4: decimation ratio R = 2^LOG2_DECIMATION. Legal range 1..10.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- DATA_IN  in  INPUT_WIDTH  signed input sample.
- DATA_IN_VALID  in  1  qualifies DATA_IN for this cycle; there is no backpressure.
- DATA_OUT  out  OUTPUT_WIDTH  signed decimated sample; held between strobes.
- DATA_OUT_VALID  out  1  one-cycle pulse when DATA_OUT updates.

Behaviour:
- Reset and width:
  - Clock is clk. Reset rst is asynchronous and active-high.
  - While rst is high, every register (integrators, comb registers, comb delays, decimation counter, strobe pipeline, DATA_OUT, DATA_OUT_VALID) is 0.
  - Internal width W = INPUT_WIDTH + STAGES*LOG2_DECIMATION. Every integrator and comb register is W bits signed.
- Integrators (pipelined): on each clock with DATA_IN_VALID=1:
  - I1 <= I1 + sign_extend(DATA_IN).
  - Ik <= Ik + I(k-1), using the pre-edge value of I(k-1), for k = 2..N.
  - With DATA_IN_VALID=0, integrators hold.
  - Arithmetic is modular two's-complement. Overflow wraps silently and is intentional; there is no saturation anywhere.
- Decimation counter:
  - Counts valid inputs 0..R-1 and wraps R-1 -> 0.
  - Invalid cycles neither count nor reset it.
  - The edge E0 that accepts a valid input while count == R-1 sets the tap strobe for one cycle.
- Tap: at edge E1 (one clock after E0), C0 <= IN (the value including E0's update) and v0 <= 1.
  - Integrators keep running at E1 if input is valid.
- Comb pipeline, one stage per clock, stage k = 1..N, when v(k-1) = 1:
  - Ck <= C(k-1) - Dk.
  - Dk <= C(k-1).
  - vk <= 1.
  - Otherwise Ck and Dk hold and vk <= 0.
- Output register, at the edge after vN = 1:
  - DATA_OUT <= CN >>> (W - OUTPUT_WIDTH), arithmetic shift (floor, no rounding).
  - DATA_OUT_VALID <= 1 for exactly one cycle; otherwise 0. DATA_OUT holds.
- Latency and rate:
  - DATA_OUT_VALID is high in the cycle following edge E(N+2).
  - Fixed latency of N+2 clocks from E0, regardless of input valid gaps after E0.
  - Exactly one output per R accepted inputs. Max input rate is one per clock.
  - Output strobes can never overlap, since R >= 2 and the comb pipeline is strobe-tracked.
- Settling: for a constant input after reset, outputs 1..N+1 are transient. From output N+2 onward, DATA_OUT equals the exact scaled DC value.
- Simultaneous events: a valid input on the same edge as a comb or output update is processed normally. Paths are independent.
- Reset mid-operation: all in-flight tap and comb strobes are discarded. No DATA_OUT_VALID is issued for samples accepted before reset. The counter restarts at 0 after release.
- The first valid input after reset release is count 0.

Test Plan:
- Defaults (14/14/N=3/R=16). DATA_IN=+1000 valid every clock for 200 clocks -> 12 DATA_OUT_VALID pulses spaced exactly 16 clocks; outputs 5..12 all equal +1000. The first pulse occurs 5 clocks after the edge accepting input #16.
- DATA_IN=-8192 constant, then +8191 constant, 20 outputs each -> settled outputs exactly -8192 and +8191. Across 10000 inputs the integrators wrap many times with no output error.
- Alternating +4000/-4000 every valid cycle (Nyquist tone) -> settled outputs all 0 (CIC null at fs/2).
- DATA_IN_VALID pseudo-random ~50% duty, 48 accepted samples of +500 -> exactly 3 pulses. Each pulse occurs 5 clocks after its 16th/32nd/48th acceptance. Invalid-cycle DATA_IN=0x1FFF is ignored.
- Assert rst for 2 cycles 2 clocks after the 16th accepted sample, while the comb strobe is in flight -> no DATA_OUT_VALID from that block; DATA_OUT=0. After release, the first pulse follows the 16th new acceptance.
- OUTPUT_WIDTH=18 with other defaults, constant +1000 -> settled DATA_OUT = +16000 (x16 scaling). DATA_OUT_VALID timing is unchanged.
